// File: rtl/fu_complete_arbiter_pkg.sv
// Shared completion-stage types: destination class, CDB packet and default FU count.
// PREG_NUMBER and XLEN may be predefined by the core; local defaults apply otherwise.
`ifndef PREG_NUMBER
`define PREG_NUMBER 64
`endif
`ifndef XLEN
`define XLEN 32
`endif

package fu_complete_arbiter_pkg;

  localparam int NUM_FU_DEF = 4;
  localparam int PREG_W     = $clog2(`PREG_NUMBER);
  localparam int DATA_W     = `XLEN;

  typedef enum logic [1:0] {
    DEST_NONE = 2'd0,
    DEST_INT  = 2'd1,
    DEST_FP   = 2'd2,
    DEST_CSR  = 2'd3
  } DEST_REG_SEL;

  localparam int SEL_W = $bits(DEST_REG_SEL);

  typedef struct packed {
    logic              valid;
    logic [PREG_W-1:0] tag;
    logic [DATA_W-1:0] data;
    DEST_REG_SEL       dest_sel;
    logic              wr_en;
  } CDB_PACKET;

  function automatic int onehot_idx(input logic [31:0] v);
    int idx;
    idx = 0;
    for (int i = 0; i < 32; i++) begin
      if (v[i]) begin
        idx = i;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/fu_complete_arbiter_rr_arbiter.sv
// Single-grant completion arbiter. COMPLETE_RR_EN selects round-robin with a
// rotating pointer; otherwise fixed priority (lowest index) with no state.
module complete_rr_arbiter
  import fu_complete_arbiter_pkg::*;
#(
  parameter int NUM_FU = NUM_FU_DEF
) (
`ifdef COMPLETE_RR_EN
  input  logic              clk,
  input  logic              reset,
`endif
  input  logic [NUM_FU-1:0] i_req,
  input  logic              i_en,
  output logic [NUM_FU-1:0] o_grant
);

`ifdef COMPLETE_RR_EN
  localparam int PTR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

  logic [PTR_W-1:0] r_ptr;
  logic [PTR_W-1:0] w_idx;
  logic             w_found;

  // Search starts at the pointer and wraps; first requester wins.
  always_comb begin
    o_grant = '0;
    w_found = 1'b0;
    w_idx   = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      w_idx = PTR_W'((int'(r_ptr) + i) % NUM_FU);
      if (i_en && !w_found && i_req[w_idx]) begin
        o_grant[w_idx] = 1'b1;
        w_found        = 1'b1;
      end
    end
  end

  // Pointer moves past each winner; blocked cycles leave it alone.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr <= '0;
    end else if (|o_grant) begin
      r_ptr <= PTR_W'((onehot_idx(32'(o_grant)) + 1) % NUM_FU);
    end else begin
      r_ptr <= r_ptr;
    end
  end
`else
  logic w_found;

  // Lowest-index requester wins.
  always_comb begin
    o_grant = '0;
    w_found = 1'b0;
    for (int i = 0; i < NUM_FU; i++) begin
      if (i_en && !w_found && i_req[i]) begin
        o_grant[i] = 1'b1;
        w_found    = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/fu_complete_arbiter.sv
// FU completion stage: grants one finished FU per cycle and broadcasts its result
// on the CDB one cycle later. COMPLETE_RR_EN selects round-robin arbitration.
module fu_complete_arbiter
  import fu_complete_arbiter_pkg::*;
#(
  parameter int NUM_FU = NUM_FU_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [1:0]               branch_recover_i,
  input  logic [NUM_FU-1:0]        fu_done_i,
  input  logic [NUM_FU*DATA_W-1:0] fu_result_i,
  input  logic [NUM_FU*PREG_W-1:0] fu_dest_reg_i,
  input  logic [NUM_FU*SEL_W-1:0]  fu_dest_sel_i,
  input  logic [NUM_FU-1:0]        fu_wr_en_i,
  output logic [NUM_FU-1:0]        complete_en_o,
  output logic                     cdb_valid_o,
  output logic [PREG_W-1:0]        cdb_tag_o,
  output logic [DATA_W-1:0]        cdb_data_o,
  output DEST_REG_SEL              cdb_dest_sel_o,
  output logic                     regfile_wr_en_o
);

  logic              w_kill;
  logic [NUM_FU-1:0] w_grant;
  CDB_PACKET         w_pkt;
  CDB_PACKET         r_cdb;

  assign w_kill = reset | (branch_recover_i != 2'b00);

  complete_rr_arbiter #(
    .NUM_FU (NUM_FU)
  ) u_arb (
`ifdef COMPLETE_RR_EN
    .clk     (clk),
    .reset   (reset),
`endif
    .i_req   (fu_done_i),
    .i_en    (~w_kill),
    .o_grant (w_grant)
  );

  // Grant is one-hot, so a plain select loop forms the winner's payload.
  always_comb begin
    w_pkt = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      if (w_grant[i]) begin
        w_pkt.valid    = 1'b1;
        w_pkt.tag      = fu_dest_reg_i[i*PREG_W +: PREG_W];
        w_pkt.data     = fu_result_i[i*DATA_W +: DATA_W];
        w_pkt.dest_sel = DEST_REG_SEL'(fu_dest_sel_i[i*SEL_W +: SEL_W]);
        w_pkt.wr_en    = fu_wr_en_i[i];
      end
    end
  end

  // Output register: load on grant, otherwise drop valid and hold the payload.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cdb <= '0;
    end else if (w_pkt.valid) begin
      r_cdb <= w_pkt;
    end else begin
      r_cdb.valid <= 1'b0;
      r_cdb.wr_en <= 1'b0;
    end
  end

  // A flush or reset in the broadcast cycle suppresses the result captured just before.
  assign complete_en_o   = w_grant;
  assign cdb_valid_o     = r_cdb.valid & ~w_kill;
  assign regfile_wr_en_o = r_cdb.valid & r_cdb.wr_en & ~w_kill;
  assign cdb_tag_o       = r_cdb.tag;
  assign cdb_data_o      = r_cdb.data;
  assign cdb_dest_sel_o  = r_cdb.dest_sel;

endmodule

// File: tb/tb_fu_complete_arbiter.sv
// Self-checking bench for fu_complete_arbiter: directed scenarios then random traffic
// against a behavioural model of FU requests and the CDB (honours COMPLETE_RR_EN).
module tb_fu_complete_arbiter;
  import fu_complete_arbiter_pkg::*;

  localparam int N = 4;

  logic                clk = 1'b0;
  logic                reset;
  logic [1:0]          branch_recover_i;
  logic [N-1:0]        fu_done_i;
  logic [N*DATA_W-1:0] fu_result_i;
  logic [N*PREG_W-1:0] fu_dest_reg_i;
  logic [N*SEL_W-1:0]  fu_dest_sel_i;
  logic [N-1:0]        fu_wr_en_i;
  logic [N-1:0]        complete_en_o;
  logic                cdb_valid_o;
  logic [PREG_W-1:0]   cdb_tag_o;
  logic [DATA_W-1:0]   cdb_data_o;
  DEST_REG_SEL         cdb_dest_sel_o;
  logic                regfile_wr_en_o;

  fu_complete_arbiter #(.NUM_FU(N)) dut (
    .clk              (clk),
    .reset            (reset),
    .branch_recover_i (branch_recover_i),
    .fu_done_i        (fu_done_i),
    .fu_result_i      (fu_result_i),
    .fu_dest_reg_i    (fu_dest_reg_i),
    .fu_dest_sel_i    (fu_dest_sel_i),
    .fu_wr_en_i       (fu_wr_en_i),
    .complete_en_o    (complete_en_o),
    .cdb_valid_o      (cdb_valid_o),
    .cdb_tag_o        (cdb_tag_o),
    .cdb_data_o       (cdb_data_o),
    .cdb_dest_sel_o   (cdb_dest_sel_o),
    .regfile_wr_en_o  (regfile_wr_en_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // FU-side model: pending result per FU and its payload
  bit                pend [N];
  bit                hold_off [N];
  logic [DATA_W-1:0] m_res [N];
  logic [PREG_W-1:0] m_dst [N];
  logic [SEL_W-1:0]  m_sel [N];
  bit                m_wr [N];
  int                m_ptr;

  // Expected CDB register contents
  bit                e_valid, e_wr, m_init;
  logic [PREG_W-1:0] e_tag;
  logic [DATA_W-1:0] e_data;
  logic [SEL_W-1:0]  e_sel;

  bit       s_reset;
  logic [1:0] s_br;

  logic [N-1:0]      obs_grant;
  logic              obs_valid, obs_wr;
  logic [PREG_W-1:0] obs_tag;
  logic [DATA_W-1:0] obs_data;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_fu(input int i, input logic [DATA_W-1:0] res, input logic [PREG_W-1:0] dst,
                        input logic [SEL_W-1:0] sel, input bit wr);
    pend[i]  = 1'b1;
    m_res[i] = res;
    m_dst[i] = dst;
    m_sel[i] = sel;
    m_wr[i]  = wr;
  endtask

  function automatic int pick_winner(input bit kill);
    if (kill) return -1;
`ifdef COMPLETE_RR_EN
    for (int k = 0; k < N; k++) begin
      if (pend[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
`else
    for (int k = 0; k < N; k++) begin
      if (pend[k]) return k;
    end
`endif
    return -1;
  endfunction

  task automatic step();
    int         g;
    bit         kill;
    logic [N-1:0] eg;
    @(negedge clk);
    reset            = s_reset;
    branch_recover_i = s_br;
    for (int i = 0; i < N; i++) begin
      fu_done_i[i]                      = pend[i];
      fu_result_i[i*DATA_W +: DATA_W]   = m_res[i];
      fu_dest_reg_i[i*PREG_W +: PREG_W] = m_dst[i];
      fu_dest_sel_i[i*SEL_W +: SEL_W]   = m_sel[i];
      fu_wr_en_i[i]                     = m_wr[i];
    end
    #1;
    kill = s_reset || (s_br != 2'b00);
    g    = pick_winner(kill);
    eg   = '0;
    if (g >= 0) eg[g] = 1'b1;
    obs_grant = complete_en_o;
    obs_valid = cdb_valid_o;
    obs_wr    = regfile_wr_en_o;
    obs_tag   = cdb_tag_o;
    obs_data  = cdb_data_o;
    check_val("grant", 64'(complete_en_o), 64'(eg));
    check_val("cdb_valid", 64'(cdb_valid_o), 64'(e_valid && !kill));
    check_val("rf_wr_en", 64'(regfile_wr_en_o), 64'(e_valid && e_wr && !kill));
    if (m_init) begin
      check_val("cdb_tag", 64'(cdb_tag_o), 64'(e_tag));
      check_val("cdb_data", 64'(cdb_data_o), 64'(e_data));
      check_val("cdb_sel", 64'(cdb_dest_sel_o), 64'(e_sel));
    end
    for (int i = 0; i < N; i++) hold_off[i] = 1'b0;
    if (s_reset) begin
      e_valid = 1'b0; e_wr = 1'b0; e_tag = '0; e_data = '0; e_sel = '0;
      m_ptr   = 0;
      m_init  = 1'b1;
    end else if (g >= 0) begin
      e_valid = 1'b1; e_wr = m_wr[g]; e_tag = m_dst[g]; e_data = m_res[g]; e_sel = m_sel[g];
      m_ptr       = (g + 1) % N;
      pend[g]     = 1'b0;
      hold_off[g] = 1'b1;
    end else begin
      e_valid = 1'b0; e_wr = 1'b0;
    end
  endtask

  initial begin
    reset = 1'b1; branch_recover_i = 2'b00; fu_done_i = '0; fu_result_i = '0;
    fu_dest_reg_i = '0; fu_dest_sel_i = '0; fu_wr_en_i = '0;
    m_init = 1'b0; m_ptr = 0; s_br = 2'b00;
    e_valid = 1'b0; e_wr = 1'b0; e_tag = '0; e_data = '0; e_sel = '0;
    for (int i = 0; i < N; i++) begin
      pend[i] = 1'b0; hold_off[i] = 1'b0; m_res[i] = '0; m_dst[i] = '0; m_sel[i] = '0; m_wr[i] = 1'b0;
    end

    // Reset held with every FU done
    s_reset = 1'b1;
    for (int i = 0; i < N; i++) set_fu(i, DATA_W'(100 + i), PREG_W'(i), 2'd1, 1'b1);
    step(); step();
    check_val("t1_en", 64'(obs_grant), 64'h0);
    check_val("t1_valid", 64'(obs_valid), 64'h0);
    for (int i = 0; i < N; i++) pend[i] = 1'b0;
    s_reset = 1'b0;

    // Single FU, 1-cycle latency
    set_fu(0, DATA_W'(8), PREG_W'(5), 2'd1, 1'b1);
    step();
    check_val("t2_en", 64'(obs_grant), 64'h1);
    step();
    check_val("t2_valid", 64'(obs_valid), 64'h1);
    check_val("t2_tag", 64'(obs_tag), 64'd5);
    check_val("t2_data", 64'(obs_data), 64'd8);
    check_val("t2_wr", 64'(obs_wr), 64'h1);
    step();
    check_val("t2_idle", 64'(obs_valid), 64'h0);

    s_reset = 1'b1; step(); s_reset = 1'b0;
`ifdef COMPLETE_RR_EN
    // All four contend: rotating grants
    for (int i = 0; i < N; i++) set_fu(i, DATA_W'(32'h40 + i), PREG_W'(20 + i), 2'd1, 1'b1);
    for (int i = 0; i < N; i++) begin
      step();
      check_val("t3_grant", 64'(obs_grant), 64'(1 << i));
    end
    step();
    check_val("t3_tag_last", 64'(obs_tag), 64'd23);
`else
    // Fixed priority: FU1 before FU3, FU0 beats pending FU3
    set_fu(1, DATA_W'(32'h11), PREG_W'(1), 2'd1, 1'b1);
    set_fu(3, DATA_W'(32'h33), PREG_W'(3), 2'd2, 1'b1);
    step(); check_val("t4_first", 64'(obs_grant), 64'h2);
    step(); check_val("t4_second", 64'(obs_grant), 64'h8);
    step();
    set_fu(3, DATA_W'(32'h34), PREG_W'(9), 2'd2, 1'b1);
    set_fu(0, DATA_W'(32'h10), PREG_W'(8), 2'd1, 1'b1);
    step(); check_val("t4_fu0_wins", 64'(obs_grant), 64'h1);
    step(); check_val("t4_fu3_next", 64'(obs_grant), 64'h8);
    step();
`endif

    // Flush right after a grant suppresses the broadcast
    set_fu(2, DATA_W'(32'hDEAD), PREG_W'(7), 2'd1, 1'b1);
    step(); check_val("t5_grant", 64'(obs_grant), 64'h4);
    s_br = 2'b01;
    set_fu(0, DATA_W'(32'h55), PREG_W'(2), 2'd1, 1'b1);
    set_fu(3, DATA_W'(32'h66), PREG_W'(3), 2'd1, 1'b1);
    step();
    check_val("t5_flush_en", 64'(obs_grant), 64'h0);
    check_val("t5_flush_valid", 64'(obs_valid), 64'h0);
    s_br = 2'b00;
    step();
    check_val("t5_after_valid", 64'(obs_valid), 64'h0);
`ifdef COMPLETE_RR_EN
    check_val("t5_ptr_kept", 64'(obs_grant), 64'h8);
`else
    check_val("t5_prio", 64'(obs_grant), 64'h1);
`endif
    step(); step();

    // Result without regfile write
    set_fu(3, DATA_W'(32'h77), PREG_W'(12), 2'd0, 1'b0);
    step(); step();
    check_val("t6_valid", 64'(obs_valid), 64'h1);
    check_val("t6_tag", 64'(obs_tag), 64'd12);
    check_val("t6_wr", 64'(obs_wr), 64'h0);

    // Random traffic with occasional flushes and resets
    for (int c = 0; c < 600; c++) begin
      s_reset = ($urandom_range(0, 49) == 0);
      s_br    = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && !hold_off[i] && $urandom_range(0, 1) == 1)
          set_fu(i, DATA_W'($urandom), PREG_W'($urandom), 2'($urandom), 1'($urandom));
      end
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
